// File: rtl/bus_host_initiator_pkg.sv
// Shared types for the single-outstanding host bus initiator.
package bus_host_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } bus_host_state_e;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_host_cmd_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        timeout;
    } bus_host_resp_t;

endpackage

// File: rtl/bus_host_initiator_if.sv
// Command, response, device-bus and status signals of the host initiator.
interface bus_host_initiator_if #(
    parameter int CountWidth = 16
);
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic                  cmd_we_i;
    logic [3:0]            cmd_be_i;
    logic [31:0]           cmd_addr_i;
    logic [31:0]           cmd_wdata_i;
    logic                  resp_valid_o;
    logic                  resp_ready_i;
    logic [31:0]           resp_rdata_o;
    logic                  resp_err_o;
    logic                  resp_timeout_o;
    logic                  host_req_o;
    logic                  host_gnt_i;
    logic                  host_we_o;
    logic [3:0]            host_be_o;
    logic [31:0]           host_addr_o;
    logic [31:0]           host_wdata_o;
    logic                  host_rvalid_i;
    logic [31:0]           host_rdata_i;
    logic                  host_err_i;
    logic                  busy_o;
    logic                  stray_o;
    logic [CountWidth-1:0] txn_count_o;

    // The initiator side.
    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_be_i, cmd_addr_i, cmd_wdata_i, resp_ready_i,
               host_gnt_i, host_rvalid_i, host_rdata_i, host_err_i,
        output cmd_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, resp_timeout_o,
               host_req_o, host_we_o, host_be_o, host_addr_o, host_wdata_o,
               busy_o, stray_o, txn_count_o
    );

    // The command source plus the device it reaches.
    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_be_i, cmd_addr_i, cmd_wdata_i, resp_ready_i,
               host_gnt_i, host_rvalid_i, host_rdata_i, host_err_i,
        input  cmd_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, resp_timeout_o,
               host_req_o, host_we_o, host_be_o, host_addr_o, host_wdata_o,
               busy_o, stray_o, txn_count_o
    );
endinterface

// File: rtl/bus_host_initiator.sv
// Single-outstanding req/gnt + rvalid bus initiator with per-phase timeout.
module bus_host_initiator
    import bus_host_pkg::*;
#(
    parameter int TimeoutCycles = 256,
    parameter int CountWidth    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    bus_host_initiator_if.master bus
);
    localparam int             TW   = $clog2(TimeoutCycles);
    localparam logic [TW-1:0]  TMAX = TW'(TimeoutCycles - 1);

    bus_host_state_e       state;
    bus_host_cmd_t         cmd_q;
    bus_host_resp_t        resp_q;
    logic [TW-1:0]         timer;
    logic [CountWidth-1:0] count;
    logic                  stray;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            cmd_q  <= '0;
            resp_q <= '0;
            timer  <= '0;
            count  <= '0;
            stray  <= 1'b0;
        end else begin
            // Responses only belong to WAIT; anything else is a protocol slip.
            if (bus.host_rvalid_i && state != WAIT) stray <= 1'b1;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (bus.cmd_valid_i) begin
                        cmd_q <= '{we: bus.cmd_we_i, be: bus.cmd_be_i,
                                   addr: bus.cmd_addr_i, wdata: bus.cmd_wdata_i};
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (bus.host_gnt_i) begin
                        timer <= '0;
                        state <= WAIT;
                    end else if (timer == TMAX) begin
                        resp_q <= '{rdata: 32'h0, err: 1'b1, timeout: 1'b1};
                        timer  <= '0;
                        state  <= RESP;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                WAIT: begin
                    if (bus.host_rvalid_i) begin
                        resp_q <= '{rdata: cmd_q.we ? 32'h0 : bus.host_rdata_i,
                                    err: bus.host_err_i, timeout: 1'b0};
                        timer  <= '0;
                        state  <= RESP;
                    end else if (timer == TMAX) begin
                        resp_q <= '{rdata: 32'h0, err: 1'b1, timeout: 1'b1};
                        timer  <= '0;
                        state  <= RESP;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                RESP: begin
                    timer <= '0;
                    if (bus.resp_ready_i) begin
                        count <= count + CountWidth'(1);
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake outputs decode the state register, so reset drops them at once.
    assign bus.cmd_ready_o    = (state == IDLE);
    assign bus.host_req_o     = (state == REQ);
    assign bus.resp_valid_o   = (state == RESP);
    assign bus.busy_o         = (state != IDLE);
    assign bus.host_we_o      = cmd_q.we;
    assign bus.host_be_o      = cmd_q.be;
    assign bus.host_addr_o    = cmd_q.addr;
    assign bus.host_wdata_o   = cmd_q.wdata;
    assign bus.resp_rdata_o   = resp_q.rdata;
    assign bus.resp_err_o     = resp_q.err;
    assign bus.resp_timeout_o = resp_q.timeout;
    assign bus.stray_o        = stray;
    assign bus.txn_count_o    = count;

endmodule

// File: tb/tb_bus_host_initiator.sv
// Scoreboard bench: expected responses queued at command issue, checked at handshake.
module tb_bus_host_initiator;
    localparam int T  = 8;
    localparam int CW = 16;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        timeout;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;
    int   exp_cnt = 0;
    exp_t exp_q[$];

    bus_host_initiator_if #(.CountWidth(CW)) ifc ();

    bus_host_initiator #(.TimeoutCycles(T), .CountWidth(CW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    endtask

    // Response monitor: the handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst && ifc.resp_valid_o === 1'b1 && ifc.resp_ready_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rdata", ifc.resp_rdata_o, e.rdata);
                chk("err", 32'(ifc.resp_err_o), 32'(e.err));
                chk("timeout", 32'(ifc.resp_timeout_o), 32'(e.timeout));
            end
            exp_cnt++;
        end
    end

    // gnt_dly / rv_dly: cycle index within the phase at which the device acts; -1 = never.
    task automatic run_txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                           input logic [31:0] wdata, input int gnt_dly, input int rv_dly,
                           input logic [31:0] dev_rdata, input logic dev_err, input int hold);
        exp_t e;
        bit   granted = 0;
        bit   to_req  = (gnt_dly < 0 || gnt_dly >= T);
        bit   to_wait = !to_req && (rv_dly < 0 || rv_dly >= T);
        int   n;
        e.timeout = to_req || to_wait;
        e.err     = e.timeout ? 1'b1 : dev_err;
        e.rdata   = (e.timeout || we) ? 32'h0 : dev_rdata;
        exp_q.push_back(e);

        ifc.cmd_valid_i = 1'b1;
        ifc.cmd_we_i    = we;
        ifc.cmd_be_i    = be;
        ifc.cmd_addr_i  = addr;
        ifc.cmd_wdata_i = wdata;
        @(posedge clk); #1;
        ifc.cmd_valid_i = 1'b0;
        ifc.cmd_addr_i  = 32'hFFFF_FFFF;
        ifc.cmd_wdata_i = 32'hFFFF_FFFF;
        chk("cmd_ready_busy", 32'(ifc.cmd_ready_o), 32'd0);

        for (int c = 0; c < T; c++) begin
            chk("host_req", 32'(ifc.host_req_o), 32'd1);
            chk("host_addr", ifc.host_addr_o, addr);
            chk("host_wdata", ifc.host_wdata_o, wdata);
            chk("host_be_we", {27'd0, ifc.host_we_o, ifc.host_be_o}, {27'd0, we, be});
            if (c == gnt_dly) begin
                ifc.host_gnt_i = 1'b1;
                @(posedge clk); #1;
                ifc.host_gnt_i = 1'b0;
                granted = 1;
                break;
            end
            @(posedge clk); #1;
        end

        if (!granted) begin
            chk("req_drop", 32'(ifc.host_req_o), 32'd0);
        end else begin
            for (int c = 0; c < T; c++) begin
                chk("wait_no_resp", 32'(ifc.resp_valid_o), 32'd0);
                if (c == rv_dly) begin
                    ifc.host_rvalid_i = 1'b1;
                    ifc.host_rdata_i  = dev_rdata;
                    ifc.host_err_i    = dev_err;
                    @(posedge clk); #1;
                    ifc.host_rvalid_i = 1'b0;
                    ifc.host_rdata_i  = 32'h0;
                    ifc.host_err_i    = 1'b0;
                    break;
                end
                @(posedge clk); #1;
            end
        end

        n = 0;
        while (ifc.resp_valid_o !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("resp_latency", 32'(n), 32'd0);

        for (int h = 0; h <= hold; h++) begin
            chk("resp_valid", 32'(ifc.resp_valid_o), 32'd1);
            chk("resp_hold_rdata", ifc.resp_rdata_o, e.rdata);
            chk("resp_hold_cmdrdy", 32'(ifc.cmd_ready_o), 32'd0);
            if (h == hold) ifc.resp_ready_i = 1'b1;
            @(posedge clk); #1;
        end
        ifc.resp_ready_i = 1'b0;
        chk("txn_count", 32'(ifc.txn_count_o), 32'(exp_cnt));
        chk("back_idle", 32'(ifc.cmd_ready_o), 32'd1);
    endtask

    initial begin
        ifc.cmd_valid_i   = 1'b0;
        ifc.cmd_we_i      = 1'b0;
        ifc.cmd_be_i      = 4'h0;
        ifc.cmd_addr_i    = 32'h0;
        ifc.cmd_wdata_i   = 32'h0;
        ifc.resp_ready_i  = 1'b0;
        ifc.host_gnt_i    = 1'b0;
        ifc.host_rvalid_i = 1'b0;
        ifc.host_rdata_i  = 32'h0;
        ifc.host_err_i    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(ifc.cmd_ready_o), 32'd1);
        chk("rst_resp_valid", 32'(ifc.resp_valid_o), 32'd0);
        chk("rst_host_req", 32'(ifc.host_req_o), 32'd0);
        chk("rst_busy", 32'(ifc.busy_o), 32'd0);
        chk("rst_stray", 32'(ifc.stray_o), 32'd0);
        chk("rst_count", 32'(ifc.txn_count_o), 32'd0);
        chk("rst_host_addr", ifc.host_addr_o, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Best-case read, then delayed-grant write returning junk rdata.
        run_txn(1'b0, 4'hF, 32'h0002_0000, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0, 0);
        chk("count_one", 32'(ifc.txn_count_o), 32'd1);
        run_txn(1'b1, 4'h3, 32'h0000_1004, 32'h1234_5678, 5, 1, 32'hFFFF_FFFF, 1'b0, 0);
        // Grant never comes; then grant / rvalid on the final allowed cycle.
        run_txn(1'b0, 4'hF, 32'h0000_2000, 32'h0, -1, 0, 32'hAAAA_5555, 1'b0, 0);
        run_txn(1'b0, 4'hF, 32'h0000_3000, 32'h0, T - 1, T - 1, 32'h0BAD_F00D, 1'b0, 0);
        // Response never comes, late rvalid in IDLE is stray, next txn still fine.
        run_txn(1'b0, 4'h1, 32'h0000_4000, 32'h0, 0, -1, 32'h1111_2222, 1'b0, 0);
        chk("stray_before", 32'(ifc.stray_o), 32'd0);
        ifc.host_rvalid_i = 1'b1;
        ifc.host_rdata_i  = 32'h5A5A_5A5A;
        @(posedge clk); #1;
        ifc.host_rvalid_i = 1'b0;
        chk("stray_set", 32'(ifc.stray_o), 32'd1);
        chk("stray_no_resp", 32'(ifc.resp_valid_o), 32'd0);
        run_txn(1'b0, 4'hF, 32'h0000_5000, 32'h0, 1, 2, 32'hCAFE_0001, 1'b0, 0);
        chk("stray_sticky", 32'(ifc.stray_o), 32'd1);
        // Device error with a back-pressured response.
        run_txn(1'b0, 4'hF, 32'h0000_6000, 32'h0, 0, 0, 32'h7777_8888, 1'b1, 4);

        // Reset in WAIT: response lost, outputs return to idle without an edge.
        ifc.cmd_valid_i = 1'b1;
        ifc.cmd_we_i    = 1'b0;
        ifc.cmd_addr_i  = 32'h0000_7000;
        @(posedge clk); #1;
        ifc.cmd_valid_i = 1'b0;
        ifc.host_gnt_i  = 1'b1;
        @(posedge clk); #1;
        ifc.host_gnt_i = 1'b0;
        chk("wait_busy", 32'(ifc.busy_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_cmd_ready", 32'(ifc.cmd_ready_o), 32'd1);
        chk("arst_host_req", 32'(ifc.host_req_o), 32'd0);
        chk("arst_busy", 32'(ifc.busy_o), 32'd0);
        chk("arst_count", 32'(ifc.txn_count_o), 32'd0);
        chk("arst_stray", 32'(ifc.stray_o), 32'd0);
        exp_cnt = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_txn(1'b0, 4'hF, 32'h0000_8000, 32'h0, 0, 0, 32'h0123_4567, 1'b0, 0);
        chk("post_rst_count", 32'(ifc.txn_count_o), 32'd1);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule

// File: doc/bus_host_initiator.md
# bus_host_initiator

Single-outstanding bus initiator that drives the simple-system device bus from the host side: req/gnt address phase, then an rvalid response phase. It accepts one read or write command at a time on a valid/ready command port and returns rdata/err on a valid/ready response port. Benches and DMA-style helpers use it to reach memory-mapped devices such as the simulator control block. A per-transaction timeout guarantees forward progress when a device never grants or never responds.

## Interface
- TimeoutCycles, 256: cycles allowed in each of REQ and WAIT before abort; legal range 2..65535.
- CountWidth, 16: width of the completed-transaction counter.

- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i
- cmd_we_i  in  1  1 = write, 0 = read
- cmd_be_i  in  4  byte enables
- cmd_addr_i  in  32  byte address
- cmd_wdata_i  in  32  write data
- resp_valid_o  out  1  response available
- resp_ready_i  in  1  response consumed
- resp_rdata_o  out  32  read data; 0 for writes and timeouts
- resp_err_o  out  1  device error or timeout
- resp_timeout_o  out  1  response produced by timeout
- host_req_o  out  1  bus request
- host_gnt_i  in  1  bus grant
- host_we_o, host_be_o, host_addr_o, host_wdata_o  out  1/4/32/32  latched command fields
- host_rvalid_i  in  1  response valid
- host_rdata_i  in  32  response data
- host_err_i  in  1  response error
- busy_o  out  1  state != IDLE
- stray_o  out  1  sticky; rvalid seen outside WAIT
- txn_count_o  out  CountWidth  completed response handshakes, wraps

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: cmd_ready_o=1. On cmd_valid_i: latch we/be/addr/wdata, clear timer, go to REQ.
- REQ: host_req_o=1. Host fields stay stable until grant. On host_gnt_i: clear timer, go to WAIT. On timer==TimeoutCycles-1 with no grant: drop req, load err=1, timeout=1, rdata=0, go to RESP.
- WAIT: on host_rvalid_i, latch err=host_err_i and timeout=0; latch rdata=host_rdata_i for reads, 0 for writes; go to RESP. On timer expiry: same error load as REQ, go to RESP.
- RESP: resp_valid_o=1 with stable fields. On resp_ready_i: txn_count_o++, go to IDLE.
- host_rvalid_i in any state other than WAIT is discarded and sets stray_o. stray_o clears only on reset.
- Grant and expiry in the same REQ cycle: the grant wins. rvalid and expiry in the same WAIT cycle: the rvalid wins.
- Timer width is $clog2(TimeoutCycles). It counts only in REQ and WAIT.

## Timing
- Reset values: state IDLE; cmd_ready_o=1; every other output, latched field, timer and counter 0.
- All outputs are registered or decoded from the state register. There are no combinational paths from inputs to outputs.
- Best case with gnt in the first REQ cycle and rvalid on the next cycle: accept at cycle 0, req at cycle 1, WAIT at cycle 2, resp_valid_o at cycle 3. Throughput is one transaction per 4 cycles.
- rvalid is sampled no earlier than the cycle after gnt. rvalid arriving in the grant cycle counts as stray.
- Reset mid-transaction: immediate return to IDLE. host_req_o drops asynchronously and the pending response is lost.

## Structure
- Package bus_host_pkg holds the state enum (bus_host_state_e), the command struct (we, be, addr, wdata) and the response struct (rdata, err, timeout).
- Single module; no sub-module is needed. The timer is inline.

## Test plan
- Read 0x0002_0000 with immediate gnt, then rvalid with rdata=0xDEADBEEF -> resp_valid_o at cycle 3 with rdata 0xDEADBEEF, err 0; txn_count_o=1.
- Write be=0x3, wdata=0x1234_5678 with gnt delayed 5 cycles -> host fields stable for all 6 REQ cycles; response rdata 0, err 0.
- gnt never asserted, TimeoutCycles=8 -> req drops after 8 REQ cycles; response err=1, timeout=1.
- Granted, rvalid never arrives, then late rvalid in IDLE -> timeout response, then stray_o=1; the next transaction completes normally.
- rvalid with host_err_i=1 -> resp_err_o=1, resp_timeout_o=0. Hold resp_ready_i low 4 cycles -> fields stable; cmd_ready_o stays 0.
- Assert rst_i during WAIT -> host_req_o=0 and cmd_ready_o=1 immediately; txn_count_o=0.
